// File: rtl/uart_485_tx.sv
// RS-485 UART transmitter: 8N1 framing with a one-entry holding buffer and
// driver-enable lead/trail guard times around each burst of back-to-back bytes.
module uart_485_tx #(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 115200,
    parameter int LEAD_BITS  = 1,
    parameter int TRAIL_BITS = 1
) (
    input  logic       clk25,
    input  logic       reset_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx,
    output logic       tx_en,
    output logic       busy
);
    localparam int              DIV        = CLK_HZ / BAUD;
    localparam int              CW         = $clog2(DIV);
    localparam logic [CW-1:0]   CNT_LAST   = CW'(DIV - 1);
    localparam logic [2:0]      LEAD_LAST  = 3'(LEAD_BITS - 1);
    localparam logic [2:0]      TRAIL_LAST = 3'(TRAIL_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LEAD, S_START, S_DATA, S_STOP, S_TRAIL
    } state_t;

    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic [2:0]    r_idx, w_idx_nxt;
    logic [7:0]    r_shift, w_shift_nxt;
    logic [7:0]    r_buf;
    logic          r_buf_full;
    logic          r_tx, r_tx_en;
    logic          w_tx_nxt, w_en_nxt;
    logic          w_load, w_accept, w_bit_end;

    assign w_accept  = tx_valid && !r_buf_full;
    assign w_bit_end = (r_cnt == CNT_LAST);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_load      = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (r_buf_full) begin
                    w_load      = 1'b1;
                    w_shift_nxt = r_buf;
                    w_idx_nxt   = '0;
                    w_state_nxt = (LEAD_BITS > 0) ? S_LEAD : S_START;
                end
            end
            S_LEAD: begin
                if (w_bit_end) begin
                    w_idx_nxt = r_idx + 3'd1;
                    if (r_idx == LEAD_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_START;
                    end
                end
            end
            S_START: begin
                if (w_bit_end) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DATA;
                end
            end
            S_DATA: begin
                if (w_bit_end) begin
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    w_idx_nxt   = r_idx + 3'd1;
                    if (r_idx == 3'd7) w_state_nxt = S_STOP;
                end
            end
            S_STOP, S_TRAIL: begin
                // A waiting byte chains straight into a new start bit without releasing the bus.
                if (w_bit_end) begin
                    w_idx_nxt = r_idx + 3'd1;
                    if (r_buf_full) begin
                        w_load      = 1'b1;
                        w_shift_nxt = r_buf;
                        w_idx_nxt   = '0;
                        w_state_nxt = S_START;
                    end else if (r_state == S_STOP) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = (TRAIL_BITS > 0) ? S_TRAIL : S_IDLE;
                    end else if (r_idx == TRAIL_LAST) begin
                        w_idx_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_cnt_nxt = (r_state == S_IDLE || w_bit_end) ? '0 : r_cnt + CW'(1);

        // Line outputs are derived from the next state so the registered pins change on the transition edge.
        unique case (w_state_nxt)
            S_START: w_tx_nxt = 1'b0;
            S_DATA:  w_tx_nxt = w_shift_nxt[0];
            default: w_tx_nxt = 1'b1;
        endcase
        w_en_nxt = (w_state_nxt != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_buf      <= '0;
            r_buf_full <= 1'b0;
            r_tx       <= 1'b1;
            r_tx_en    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
            r_tx    <= w_tx_nxt;
            r_tx_en <= w_en_nxt;
            if (w_load) begin
                r_buf_full <= 1'b0;
            end else if (w_accept) begin
                r_buf      <= tx_data;
                r_buf_full <= 1'b1;
            end
        end
    end

    assign tx       = r_tx;
    assign tx_en    = r_tx_en;
    assign tx_ready = !r_buf_full;
    assign busy     = (r_state != S_IDLE) || r_buf_full;
endmodule

// File: tb/tb_uart_485_tx.sv
// Scoreboard bench for uart_485_tx: two instances (guard bits 1/1 and 0/0), line decoded
// by a monitor and compared against bytes queued at each accept edge.
module tb_uart_485_tx;
    localparam int DIV = 8;
    localparam int L0  = 1;
    localparam int T0  = 1;

    logic       clk = 1'b0;
    logic [1:0] rst_n = 2'b00;
    logic [1:0] valid = 2'b00;
    logic [7:0] data [2];
    logic       tx0, tx1, en0, en1, rdy0, rdy1, busy0, busy1;
    wire  [1:0] tx_w   = {tx1, tx0};
    wire  [1:0] en_w   = {en1, en0};
    wire  [1:0] rdy_w  = {rdy1, rdy0};
    wire  [1:0] busy_w = {busy1, busy0};

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int run0  = 0;
    int run1  = 0;
    logic [7:0] exp0[$], exp1[$];
    int starts0[$], starts1[$], runs0[$], runs1[$];

    uart_485_tx #(.CLK_HZ(8), .BAUD(1), .LEAD_BITS(L0), .TRAIL_BITS(T0)) dut (
        .clk25(clk), .reset_n(rst_n[0]), .tx_data(data[0]), .tx_valid(valid[0]),
        .tx_ready(rdy0), .tx(tx0), .tx_en(en0), .busy(busy0));

    uart_485_tx #(.CLK_HZ(8), .BAUD(1), .LEAD_BITS(0), .TRAIL_BITS(0)) dut_nog (
        .clk25(clk), .reset_n(rst_n[1]), .tx_data(data[1]), .tx_valid(valid[1]),
        .tx_ready(rdy1), .tx(tx1), .tx_en(en1), .busy(busy1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // tx_en burst lengths, measured on the falling edge of the enable.
    always @(negedge clk) begin
        if (en_w[0]) run0++;
        else if (run0 > 0) begin runs0.push_back(run0); run0 = 0; end
        if (en_w[1]) run1++;
        else if (run1 > 0) begin runs1.push_back(run1); run1 = 0; end
    end

    function automatic int run_cnt(input int k);
        return (k == 0) ? runs0.size() : runs1.size();
    endfunction

    task automatic wait_runs(input int k, input int n);
        int t = 0;
        while (run_cnt(k) < n && t < 1000) begin @(negedge clk); t++; end
        if (run_cnt(k) < n) begin
            n_cmp++; n_err++;
            $display("FAIL burst_timeout: inst %0d saw %0d bursts, expected %0d", k, run_cnt(k), n);
        end
    endtask

    // Call on a negedge; returns on the negedge after the accepting edge.
    task automatic send(input int k, input logic [7:0] b, output int acc, output int waits);
        waits = 0;
        while (!rdy_w[k] && waits < 2000) begin @(negedge clk); waits++; end
        if (!rdy_w[k]) begin
            n_cmp++; n_err++;
            $display("FAIL ready_timeout: inst %0d ready=%0b, expected 1", k, rdy_w[k]);
        end
        data[k]  = b;
        valid[k] = 1'b1;
        @(posedge clk);
        if (k == 0) exp0.push_back(b); else exp1.push_back(b);
        @(negedge clk);
        acc      = cyc;
        valid[k] = 1'b0;
        data[k]  = 8'($urandom);
    endtask

    task automatic monitor(input int k);
        forever begin
            @(negedge clk);
            if (rst_n[k] && !tx_w[k]) begin
                logic [9:0] bits = '0;
                int en_bad = 0;
                bit aborted = 1'b0;
                logic [7:0] e;
                if (k == 0) starts0.push_back(cyc); else starts1.push_back(cyc);
                for (int i = 0; i < 10 * DIV; i++) begin
                    if (i > 0) @(negedge clk);
                    if (!rst_n[k]) begin aborted = 1'b1; break; end
                    if (!en_w[k]) en_bad++;
                    if (i % DIV == DIV / 2) bits[i / DIV] = tx_w[k];
                end
                if (!aborted) begin
                    check("start_bit", int'(bits[0]), 0);
                    check("stop_bit", int'(bits[9]), 1);
                    check("en_during_frame", en_bad, 0);
                    if ((k == 0 ? exp0.size() : exp1.size()) == 0) begin
                        n_cmp++; n_err++;
                        $display("FAIL unexpected_frame: inst %0d byte 0x%02h, expected none", k, bits[8:1]);
                    end else begin
                        e = (k == 0) ? exp0.pop_front() : exp1.pop_front();
                        check("frame_data", int'(bits[8:1]), int'(e));
                    end
                end
            end
        end
    endtask

    task automatic random_traffic(input int k);
        int acc, w, gap;
        for (int n = 0; n < 30; n++) begin
            gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 120) : $urandom_range(0, 5);
            repeat (gap) @(negedge clk);
            send(k, 8'($urandom), acc, w);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, w, bad, t;
        data[0] = 8'($urandom);
        data[1] = 8'($urandom);
        fork
            monitor(0);
            monitor(1);
        join_none

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("rst_tx", int'(tx_w[k]), 1);
            check("rst_en", int'(en_w[k]), 0);
            check("rst_ready", int'(rdy_w[k]), 1);
            check("rst_busy", int'(busy_w[k]), 0);
        end

        // No guard bits: accept on the first edge after release, start bit 1 clk later.
        rst_n = 2'b11;
        starts1.delete(); runs1.delete();
        send(1, 8'h80, acc, w);
        check("first_accept_wait", w, 0);
        wait_runs(1, 1);
        check("nog_latency", starts1[0] - acc, 1);
        check("nog_en_run", runs1[0], 10 * DIV);

        // Single byte with lead/trail.
        starts0.delete(); runs0.delete();
        send(0, 8'h55, acc, w);
        check("ready_after_accept", int'(rdy_w[0]), 0);
        check("busy_after_accept", int'(busy_w[0]), 1);
        check("en_at_accept", int'(en_w[0]), 0);
        @(negedge clk);
        check("en_rise", int'(en_w[0]), 1);
        wait_runs(0, 1);
        check("single_latency", starts0[0] - acc, 1 + L0 * DIV);
        check("single_en_run", runs0[0], (L0 + 10 + T0) * DIV);

        // Back-to-back: second byte waits in the buffer.
        starts0.delete(); runs0.delete();
        send(0, 8'hA3, acc, w);
        check("b2b_ready_low", int'(rdy_w[0]), 0);
        send(0, 8'h0F, acc2, w);
        check("b2b_reload_wait", w, 1);
        wait_runs(0, 1);
        check("b2b_gap", starts0[1] - starts0[0], 10 * DIV);
        check("b2b_en_run", runs0[0], (L0 + 20 + T0) * DIV);

        // Byte accepted 3 clks into TRAIL: start at the end of that trail bit.
        starts0.delete(); runs0.delete();
        send(0, 8'h11, acc, w);
        t = 0;
        while (cyc < acc + 1 + (L0 + 10) * DIV + 2 && t < 500) begin @(negedge clk); t++; end
        send(0, 8'hFF, acc2, w);
        check("trail_accept_wait", w, 0);
        wait_runs(0, 1);
        check("trail_abort_start", starts0[1] - acc2, DIV - 3);
        check("trail_en_run", runs0[0], (L0 + 10 + 1 + 10 + T0) * DIV);

        // Reset during data bit 3 of 0x00.
        starts0.delete();
        send(0, 8'h00, acc, w);
        t = 0;
        while (cyc < acc + 1 + L0 * DIV + 4 * DIV + 3 && t < 500) begin @(negedge clk); t++; end
        rst_n[0] = 1'b0;
        #1;
        check("midrst_tx", int'(tx_w[0]), 1);
        check("midrst_en", int'(en_w[0]), 0);
        check("midrst_ready", int'(rdy_w[0]), 1);
        check("midrst_busy", int'(busy_w[0]), 0);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        exp0.delete(); starts0.delete();
        bad = 0;
        repeat (120) begin
            @(negedge clk);
            if (tx_w[0] !== 1'b1 || en_w[0] !== 1'b0) bad++;
        end
        check("post_reset_idle", bad, 0);
        check("post_reset_frames", starts0.size(), 0);

        fork
            random_traffic(0);
            random_traffic(1);
        join
        t = 0;
        while ((exp0.size() + exp1.size()) > 0 && t < 2000) begin @(negedge clk); t++; end
        check("leftover_bytes", exp0.size() + exp1.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
